// File: rtl/cnn_result_writer.sv
// cnn_result_writer: stores the flattened CNN output vector in the shared RAM for the FC DMA.
//
// Accepts a valid/ready word stream from the last CNN stage, optionally clamps negative words to
// zero (ReLU), and writes each word to BASE_ADDR + index through a one-entry holding register in
// front of the RAM write port. When the last word of the frame has been acked by the RAM,
// cnn_done pulses for one cycle to start the FC fetch.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   start               begin a frame (honoured only when idle)
//   in_valid/in_data    CNN word stream (two's complement)
//   in_ready            word is accepted this cycle
//   ram_we/addr/wdata   RAM write request; held stable until ram_ack
//   ram_ack             RAM accepts the write this cycle
//   busy                frame in progress
//   word_count          writes acked in the current frame
//   cnn_done            one-cycle pulse: frame fully in RAM
module cnn_result_writer #(
  parameter int unsigned WORD_SIZE  = 16,
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned NUM_WORDS  = 128,
  parameter int unsigned BASE_ADDR  = 0,
  parameter int unsigned RELU       = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  in_valid,
  input  logic [WORD_SIZE-1:0]  in_data,
  output logic                  in_ready,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [WORD_SIZE-1:0]  ram_wdata,
  input  logic                  ram_ack,
  output logic                  busy,
  output logic [ADDR_WIDTH-1:0] word_count,
  output logic                  cnn_done
);

  // One extra bit so a frame of exactly 2^ADDR_WIDTH words can be counted.
  localparam int unsigned CntW = ADDR_WIDTH + 1;
  localparam logic [CntW-1:0]       NumWords = CntW'(NUM_WORDS);
  localparam logic [CntW-1:0]       LastWord = CntW'(NUM_WORDS - 1);
  localparam logic [ADDR_WIDTH-1:0] BaseAddr = ADDR_WIDTH'(BASE_ADDR);

  typedef enum logic [1:0] {StIdle, StWrite, StDone} state_e;

  state_e                state_q;
  logic [CntW-1:0]       acc_cnt_q;
  logic [CntW-1:0]       wr_cnt_q;
  logic                  hold_valid_q;
  logic [WORD_SIZE-1:0]  hold_data_q;
  logic [ADDR_WIDTH-1:0] hold_addr_q;

  logic                  accept;
  logic                  ack;
  logic [WORD_SIZE-1:0]  relu_data;
  logic [ADDR_WIDTH-1:0] next_addr;

  // The holding register may be refilled in the same cycle its current word is acked,
  // which is what allows one word per cycle.
  assign in_ready  = (state_q == StWrite) && (acc_cnt_q < NumWords) &&
                     (!hold_valid_q || ram_ack);
  assign accept    = in_valid && in_ready;
  assign ack       = hold_valid_q && ram_ack;
  assign relu_data = ((RELU != 0) && in_data[WORD_SIZE-1]) ? '0 : in_data;
  // Address wraps modulo 2^ADDR_WIDTH.
  assign next_addr = BaseAddr + acc_cnt_q[ADDR_WIDTH-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      acc_cnt_q    <= '0;
      wr_cnt_q     <= '0;
      hold_valid_q <= 1'b0;
      hold_data_q  <= '0;
      hold_addr_q  <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (start) begin
            state_q      <= StWrite;
            acc_cnt_q    <= '0;
            wr_cnt_q     <= '0;
            hold_valid_q <= 1'b0;
          end
        end
        StWrite: begin
          if (accept) begin
            hold_data_q  <= relu_data;
            hold_addr_q  <= next_addr;
            hold_valid_q <= 1'b1;
            acc_cnt_q    <= acc_cnt_q + CntW'(1);
          end else if (ack) begin
            hold_valid_q <= 1'b0;
          end
          if (ack) begin
            wr_cnt_q <= wr_cnt_q + CntW'(1);
            if (wr_cnt_q == LastWord) begin
              state_q <= StDone;
            end
          end
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign ram_we     = hold_valid_q;
  assign ram_addr   = hold_addr_q;
  assign ram_wdata  = hold_data_q;
  assign busy       = (state_q == StWrite);
  assign cnn_done   = (state_q == StDone);
  assign word_count = wr_cnt_q[ADDR_WIDTH-1:0];

endmodule

// File: tb/tb_cnn_result_writer.sv
// Self-checking bench for cnn_result_writer.
// DUT a: 128-word frames at base 0x0100 with ReLU; checked every cycle against a frame-level
// model (expected writes queue, word counts, idle/active/done phase).
// DUT b: 4-word frame at base 0xFE in an 8-bit address space without ReLU (wrap + pass-through),
// checked from a vector table.
module tb_cnn_result_writer;

  localparam int N = 128;
  localparam int BASE = 16'h0100;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0, in_valid = 1'b0, ram_ack = 1'b0;
  logic [15:0] in_data = '0;
  logic        in_ready, ram_we, busy, cnn_done;
  logic [15:0] ram_addr, ram_wdata, word_count;

  logic        b_start = 1'b0, b_in_valid = 1'b0, b_ram_ack = 1'b1;
  logic [15:0] b_in_data = '0;
  logic        b_in_ready, b_ram_we, b_busy, b_cnn_done;
  logic [7:0]  b_ram_addr, b_word_count;
  logic [15:0] b_ram_wdata;

  always #5 clk = ~clk;

  cnn_result_writer #(
    .WORD_SIZE(16), .ADDR_WIDTH(16), .NUM_WORDS(N), .BASE_ADDR(BASE), .RELU(1)
  ) dut_a (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_ack(ram_ack), .busy(busy), .word_count(word_count), .cnn_done(cnn_done)
  );

  cnn_result_writer #(
    .WORD_SIZE(16), .ADDR_WIDTH(8), .NUM_WORDS(4), .BASE_ADDR(8'hFE), .RELU(0)
  ) dut_b (
    .clk(clk), .rst(rst), .start(b_start), .in_valid(b_in_valid), .in_data(b_in_data),
    .in_ready(b_in_ready), .ram_we(b_ram_we), .ram_addr(b_ram_addr),
    .ram_wdata(b_ram_wdata), .ram_ack(b_ram_ack), .busy(b_busy),
    .word_count(b_word_count), .cnn_done(b_cnn_done)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] relu(input logic [15:0] d);
    return d[15] ? 16'h0000 : d;
  endfunction

  // ---------------- frame-level reference model for DUT a ----------------
  typedef enum int {MIdle, MActive, MDone} mphase_e;
  mphase_e     m_st = MIdle;
  int          m_acc = 0;
  int          m_wr = 0;
  logic [15:0] pend_data_q[$];
  logic [15:0] pend_addr_q[$];
  logic [15:0] wr_log [0:N-1];
  logic [15:0] src [0:N-1];

  task automatic monitor_step();
    bit exp_ready;
    exp_ready = (m_st == MActive) && (m_acc < N) && (pend_data_q.size() == 0 || ram_ack);
    if (rst) begin
      m_st = MIdle;
      m_acc = 0;
      m_wr = 0;
      pend_data_q.delete();
      pend_addr_q.delete();
    end else begin
      check("busy", busy, m_st == MActive);
      check("cnn_done", cnn_done, m_st == MDone);
      check("in_ready", in_ready, exp_ready);
      check("ram_we", ram_we, pend_data_q.size() != 0);
      check("word_count", word_count, m_wr);
      if (pend_data_q.size() != 0) begin
        // Compared every cycle the write is pending, so this also proves stability.
        check("ram_addr", ram_addr, pend_addr_q[0]);
        check("ram_wdata", ram_wdata, pend_data_q[0]);
      end
      case (m_st)
        MIdle: begin
          if (start) begin
            m_st = MActive;
            m_acc = 0;
            m_wr = 0;
          end
        end
        MActive: begin
          if (pend_data_q.size() != 0 && ram_ack) begin
            wr_log[m_wr] = pend_data_q[0];
            void'(pend_data_q.pop_front());
            void'(pend_addr_q.pop_front());
            m_wr++;
          end
          if (in_valid && exp_ready) begin
            pend_data_q.push_back(relu(in_data));
            pend_addr_q.push_back(16'(BASE + m_acc));
            m_acc++;
          end
          if (m_wr == N) m_st = MDone;
        end
        default: m_st = MIdle;
      endcase
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      monitor_step();
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // mode 0: continuous valid/ack with a stray start at t=60; mode 1: random valid, ack every
  // other cycle. stop_at > 0 returns once that many writes are acked.
  task automatic run_frame(input int mode, input int stop_at);
    bit finished = 0;
    start = 1'b1;
    cyc();
    start = 1'b0;
    for (int t = 0; t < 3000; t++) begin
      if (t > 0 && m_st == MIdle) begin
        finished = 1;
        break;
      end
      if (stop_at > 0 && m_wr >= stop_at) begin
        finished = 1;
        break;
      end
      if (mode == 0) begin
        if (t == 128) check("ready_after_last_word", in_ready, 0);
        if (t == 129) begin
          check("done_at_E129", cnn_done, 1);
          check("word_count_at_done", word_count, N);
        end
        start    = (t == 60);
        in_valid = 1'b1;
        ram_ack  = 1'b1;
      end else begin
        in_valid = 1'($urandom_range(0, 1));
        ram_ack  = t[0];
      end
      in_data = (m_acc < N) ? src[m_acc] : 16'hDEAD;
      cyc();
    end
    start = 1'b0;
    in_valid = 1'b0;
    ram_ack = 1'b0;
    check("frame_complete", finished, 1);
  endtask

  typedef struct {
    logic [15:0] din;
    logic [15:0] exp_relu;
    logic [7:0]  exp_b_addr;
    logic [15:0] exp_b_data;
  } vec_t;

  vec_t tbl [4];

  initial begin
    bit ok;
    tbl[0] = '{16'h8000, 16'h0000, 8'hFE, 16'h8000};
    tbl[1] = '{16'hFF00, 16'h0000, 8'hFF, 16'hFF00};
    tbl[2] = '{16'h0100, 16'h0100, 8'h00, 16'h0100};
    tbl[3] = '{16'h7FFF, 16'h7FFF, 8'h01, 16'h7FFF};

    // Reset state
    repeat (3) cyc();
    check("rst_in_ready", in_ready, 0);
    check("rst_ram_we", ram_we, 0);
    check("rst_ram_addr", ram_addr, 0);
    check("rst_ram_wdata", ram_wdata, 0);
    check("rst_busy", busy, 0);
    check("rst_word_count", word_count, 0);
    check("rst_cnn_done", cnn_done, 0);
    check("rst_b_ram_addr", b_ram_addr, 0);
    check("rst_b_busy", b_busy, 0);
    rst = 1'b0;

    // in_valid while idle: nothing accepted or written (monitor checks)
    in_valid = 1'b1;
    in_data = 16'h1234;
    repeat (5) cyc();
    in_valid = 1'b0;

    // Streaming frame: data = index, addresses 0x0100..0x017F
    for (int k = 0; k < N; k++) src[k] = 16'(k);
    run_frame(0, 0);
    repeat (3) cyc();

    // ReLU vectors at the head of a backpressured random frame
    for (int k = 0; k < N; k++) src[k] = 16'($urandom);
    for (int i = 0; i < 4; i++) src[i] = tbl[i].din;
    run_frame(1, 0);
    for (int i = 0; i < 4; i++) check("relu_word", wr_log[i], tbl[i].exp_relu);
    repeat (2) cyc();

    // Reset mid-frame at word 50, then a full frame
    for (int k = 0; k < N; k++) src[k] = 16'($urandom);
    run_frame(0, 50);
    in_valid = 1'b1;
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    check("midrst_in_ready", in_ready, 0);
    check("midrst_ram_we", ram_we, 0);
    check("midrst_ram_addr", ram_addr, 0);
    check("midrst_ram_wdata", ram_wdata, 0);
    check("midrst_busy", busy, 0);
    check("midrst_word_count", word_count, 0);
    check("midrst_cnn_done", cnn_done, 0);
    in_valid = 1'b0;
    repeat (5) cyc();
    run_frame(1, 0);
    repeat (2) cyc();

    // DUT b: address wrap and ReLU disabled
    b_start = 1'b1;
    cyc();
    b_start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      b_in_valid = 1'b1;
      b_in_data = tbl[i].din;
      ok = 0;
      for (int w = 0; w < 20; w++) begin
        @(negedge clk);
        if (b_in_ready) begin
          ok = 1;
          break;
        end
      end
      check("b_ready_seen", ok, 1);
      cyc();
      b_in_valid = 1'b0;
      check("b_ram_we", b_ram_we, 1);
      check("b_ram_addr", b_ram_addr, tbl[i].exp_b_addr);
      check("b_ram_wdata", b_ram_wdata, tbl[i].exp_b_data);
    end
    ok = 0;
    for (int w = 0; w < 20; w++) begin
      @(negedge clk);
      if (b_cnn_done) begin
        ok = 1;
        check("b_word_count_at_done", b_word_count, 4);
        break;
      end
    end
    check("b_done_seen", ok, 1);
    @(negedge clk);
    check("b_done_one_cycle", b_cnn_done, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
